// File: rtl/alu_pkg.sv
// ALU request types shared by the issue stage and its request FIFO.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
//
// Contents: opcode_t (ALU opcodes), alu_req_t (one buffered request),
// is_legal() (true for opcodes alu_add implements).
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OPC_W  = 4;
  localparam int ALU_TAG_W  = 4;

  typedef enum logic [ALU_OPC_W-1:0] {
    OPCODE_ADD = 4'd0,
    OPCODE_SUB = 4'd1,
    OPCODE_LT  = 4'd2,
    OPCODE_GT  = 4'd3
  } opcode_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_OPC_W-1:0]  opcode;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_req_t;

  function automatic logic is_legal(input opcode_t op);
    case (op)
      OPCODE_ADD, OPCODE_SUB, OPCODE_LT, OPCODE_GT: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous request FIFO for the ALU issue stage; head is read combinationally.
// Latency: a push is visible at the head one edge later.
// Backpressure: caller must not push when full nor pop when empty.
//
// Ports: clk, rst_n (async active-low), push/push_data, pop, head,
// full, empty, count (occupancy, 0..DEPTH).
module alu_issue_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_req_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T                mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Storage carries no reset: only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// Operand/issue stage: buffers ALU requests and issues one per cycle to alu_add.
// Latency: request accepted at edge N appears in the output slot after edge N+1.
// Backpressure: in_ready drops when the FIFO is full; issue stalls while the slot is held.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_opcode/in_tag
// request side; alu_a/alu_b/alu_opcode/alu_en to alu_add, alu_result back;
// out_valid/out_ready/out_result/out_tag/out_illegal result slot; count = FIFO occupancy.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int OPC_W  = 4,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [OPC_W-1:0]         in_opcode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [OPC_W-1:0]         alu_opcode,
  output logic                     alu_en,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  // Same field layout as alu_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OPC_W-1:0]  opcode;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t req_in;
  req_t head;
  logic full;
  logic empty;
  logic push;
  logic issue;
  logic head_legal;

  assign req_in = '{a: in_a, b: in_b, opcode: in_opcode, tag: in_tag};

  // No pass-through when full: in_ready depends only on occupancy.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  // Issue whenever there is work and the slot is empty or being drained now.
  assign issue    = !empty && (!out_valid || out_ready);

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (req_in),
    .pop       (issue),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // ALU operands are zeroed when idle so the combinational ALU does not toggle.
  assign alu_en     = issue;
  assign alu_a      = issue ? head.a      : '0;
  assign alu_b      = issue ? head.b      : '0;
  assign alu_opcode = issue ? head.opcode : '0;

  assign head_legal = is_legal(opcode_t'(head.opcode));

  // Illegal opcodes are still issued; the flag travels with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_tag     <= head.tag;
      out_illegal <= !head_legal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
